// File: rtl/dm_be_clr_pkg.sv
// Shared definitions for the byte-enable data memory with hardware clear.
// Holds the access-size encodings, the FSM state type and lane-decode helpers.
package dm_be_clr_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        StClear,
        StIdle
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension; purely combinational.
module dm_load_ext
    import dm_be_clr_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_data = 32'h0;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sext & w_half[15]}}, w_half};
            SZ_WORD: o_data = i_word;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_be_clr.sv
// Byte-enable data memory with registered load path and a post-reset clear sequence
// that zeroes one word per cycle while BUSY is high.
module dm_be_clr
    import dm_be_clr_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        RE,
    input  logic        WE,
    input  logic [1:0]  SIZE,
    input  logic        SEXT,
    input  logic [31:0] PC,
    output logic [31:0] RD,
    output logic        RD_VALID,
    output logic        BUSY,
    output logic        ADDR_ERR
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    logic [31:0]      r_mem [DEPTH_WORDS];
    state_e           r_state;
    logic [IDX_W-1:0] r_cnt;
    logic [31:0]      r_rd;
    logic             r_rd_valid;
    logic             r_addr_err;

    logic [IDX_W-1:0] w_idx;
    logic             w_mis;
    logic             w_accept;
    logic [31:0]      w_rword;
    logic [31:0]      w_ext;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [3:0]       w_wr_be;
    logic [31:0]      w_wr_data;
    logic             w_unused;

    // PC only feeds the external store log; upper address bits wrap away.
    assign w_unused = ^{PC, A[31:IDX_W+2]};

    assign w_idx    = A[IDX_W+1:2];
    assign w_mis    = is_misaligned(SIZE, A[1:0]);
    assign w_accept = (r_state == StIdle) && !Reset && (RE || WE);
    assign w_rword  = r_mem[w_idx];

    dm_load_ext u_load_ext (
        .i_word (w_rword),
        .i_lane (A[1:0]),
        .i_size (SIZE),
        .i_sext (SEXT),
        .o_data (w_ext)
    );

    // Single write port shared by the clear sequence and committed stores.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_idx;
        w_wr_be   = 4'b0000;
        w_wr_data = 32'h0;
        if (r_state == StClear) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_cnt;
            w_wr_be  = 4'b1111;
        end else if (w_accept && WE && !w_mis) begin
            w_wr_en = 1'b1;
            w_wr_be = byte_en(SIZE, A[1:0]);
            case (SIZE)
                SZ_BYTE: w_wr_data = {4{WD[7:0]}};
                SZ_HALF: w_wr_data = {2{WD[15:0]}};
                default: w_wr_data = WD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= StClear;
            r_cnt      <= '0;
            r_rd       <= 32'h0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rd       <= 32'h0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                StClear: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) r_state <= StIdle;
                end
                default: begin
                    if (w_accept) begin
                        r_addr_err <= w_mis;
                        if (RE && !w_mis) begin
                            r_rd_valid <= 1'b1;
                            r_rd       <= w_ext;
                        end
                    end
                end
            endcase
        end
    end

    assign RD       = r_rd;
    assign RD_VALID = r_rd_valid;
    assign ADDR_ERR = r_addr_err;
    assign BUSY     = (r_state == StClear);

endmodule

// File: tb/tb_dm_be_clr.sv
// Directed, table-driven bench for dm_be_clr at DEPTH_WORDS=16, plus reset/clear sequences.
module tb_dm_be_clr;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] A, WD, PC;
    logic        RE, WE, SEXT;
    logic [1:0]  SIZE;
    logic [31:0] RD;
    logic        RD_VALID, BUSY, ADDR_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        re;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] model [16];

    dm_be_clr #(
        .DEPTH_WORDS (16),
        .IDX_W       (4)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .A        (A),
        .WD       (WD),
        .RE       (RE),
        .WE       (WE),
        .SIZE     (SIZE),
        .SEXT     (SEXT),
        .PC       (PC),
        .RD       (RD),
        .RD_VALID (RD_VALID),
        .BUSY     (BUSY),
        .ADDR_ERR (ADDR_ERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic re, input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] a, input logic [31:0] wd, input logic ev,
                       input logic ee, input logic [31:0] erd);
        vec_t v;
        v = '{re: re, we: we, size: size, sext: sext, a: a, wd: wd,
              exp_valid: ev, exp_err: ee, exp_rd: erd};
        vecs.push_back(v);
    endtask

    // Counts BUSY cycles from the current negedge; returns count and any stray response.
    task automatic count_busy(output int n, output logic stray);
        n = 0;
        stray = 1'b0;
        while (BUSY === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            if (BUSY === 1'b1 && (RD_VALID !== 1'b0 || ADDR_ERR !== 1'b0)) stray = 1'b1;
        end
    endtask

    initial begin
        int          nb;
        logic        stray;
        logic [31:0] w;
        logic [3:0]  wi;

        Reset = 1'b1; A = 32'h0; WD = 32'h0; PC = 32'h0;
        RE = 1'b1; WE = 1'b0; SIZE = 2'b10; SEXT = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // Reset held with a pending request: nothing may be accepted.
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'h0, BUSY}, 32'h1);
        chk("reset_rd_valid", {31'h0, RD_VALID}, 32'h0);
        chk("reset_addr_err", {31'h0, ADDR_ERR}, 32'h0);
        chk("reset_rd", RD, 32'h0);
        Reset = 1'b0;
        RE = 1'b0;
        count_busy(nb, stray);
        chk("clear_cycles", nb, 16);

        // Vectors: re, we, size, sext, a, wd, exp_valid, exp_err, exp_rd
        add(1, 0, 2'b10, 0, 32'h00, 32'h0,        1, 0, 32'h0);
        add(1, 0, 2'b10, 0, 32'h3C, 32'h0,        1, 0, 32'h0);
        add(1, 0, 2'b00, 1, 32'h27, 32'h0,        1, 0, 32'h0);
        add(0, 1, 2'b10, 0, 32'h10, 32'h8000FF7F, 0, 0, 32'h0);
        add(1, 0, 2'b00, 1, 32'h10, 32'h0,        1, 0, 32'h0000007F);
        add(1, 0, 2'b00, 1, 32'h11, 32'h0,        1, 0, 32'hFFFFFFFF);
        add(1, 0, 2'b01, 1, 32'h12, 32'h0,        1, 0, 32'hFFFF8000);
        add(1, 0, 2'b01, 0, 32'h12, 32'h0,        1, 0, 32'h00008000);
        add(1, 0, 2'b00, 0, 32'h11, 32'h0,        1, 0, 32'h000000FF);
        add(1, 0, 2'b10, 1, 32'h10, 32'h0,        1, 0, 32'h8000FF7F);
        add(0, 1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, 32'h0);
        add(0, 1, 2'b00, 0, 32'h21, 32'hFFFFFFAB, 0, 0, 32'h0);
        add(1, 0, 2'b10, 0, 32'h20, 32'h0,        1, 0, 32'h1122AB44);
        add(0, 1, 2'b01, 0, 32'h22, 32'h5555BEEF, 0, 0, 32'h0);
        add(1, 0, 2'b10, 0, 32'h20, 32'h0,        1, 0, 32'hBEEFAB44);
        add(1, 0, 2'b10, 0, 32'h02, 32'h0,        0, 1, 32'h0);
        add(0, 1, 2'b01, 0, 32'h03, 32'h1234,     0, 1, 32'h0);
        add(1, 0, 2'b11, 0, 32'h20, 32'h0,        0, 1, 32'h0);
        add(0, 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 0, 1, 32'h0);
        add(1, 0, 2'b10, 0, 32'h20, 32'h0,        1, 0, 32'hBEEFAB44);
        add(1, 0, 2'b10, 0, 32'h00, 32'h0,        1, 0, 32'h0);
        add(0, 0, 2'b10, 0, 32'h20, 32'h0,        0, 0, 32'h0);
        add(0, 1, 2'b10, 0, 32'h30, 32'h5,        0, 0, 32'h0);
        add(1, 1, 2'b10, 0, 32'h30, 32'h9,        1, 0, 32'h5);
        add(1, 0, 2'b10, 0, 32'h30, 32'h0,        1, 0, 32'h9);
        add(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 0, 0, 32'h0);
        add(1, 0, 2'b10, 0, 32'h00, 32'h0,        1, 0, 32'hCAFEF00D);
        add(1, 0, 2'b01, 0, 32'h42, 32'h0,        1, 0, 32'h0000CAFE);
        add(0, 1, 2'b00, 0, 32'h13, 32'h12,       0, 0, 32'h0);
        add(1, 0, 2'b00, 1, 32'h13, 32'h0,        1, 0, 32'h00000012);
        add(1, 0, 2'b10, 0, 32'h10, 32'h0,        1, 0, 32'h1200FF7F);
        add(1, 0, 2'b01, 1, 32'h10, 32'h0,        1, 0, 32'hFFFFFF7F);

        foreach (vecs[i]) begin
            A = vecs[i].a; WD = vecs[i].wd; RE = vecs[i].re; WE = vecs[i].we;
            SIZE = vecs[i].size; SEXT = vecs[i].sext; PC = 32'h1000 + 32'(i) * 4;
            @(negedge clk);
            RE = 1'b0; WE = 1'b0;
            chk($sformatf("v%0d_rd_valid", i), {31'h0, RD_VALID}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("v%0d_addr_err", i), {31'h0, ADDR_ERR}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_rd", i), RD, vecs[i].exp_rd);
            if (vecs[i].we && !vecs[i].exp_err) begin
                wi = vecs[i].a[5:2];
                w = model[wi];
                case (vecs[i].size)
                    2'b00:   w[{vecs[i].a[1:0], 3'b000} +: 8] = vecs[i].wd[7:0];
                    2'b01:   w[{vecs[i].a[1], 4'b0000} +: 16] = vecs[i].wd[15:0];
                    default: w = vecs[i].wd;
                endcase
                model[wi] = w;
                $display("@%08h: *%08h <= %08h", PC, vecs[i].a, w);
            end
        end

        // Reset pulse, then a second reset once CNT has reached 7.
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        repeat (7) @(negedge clk);
        chk("busy_at_cnt7", {31'h0, BUSY}, 32'h1);
        Reset = 1'b1;
        RE = 1'b1; A = 32'h10; SIZE = 2'b10; SEXT = 1'b0;
        @(negedge clk);
        chk("rereset_busy", {31'h0, BUSY}, 32'h1);
        chk("rereset_rd_valid", {31'h0, RD_VALID}, 32'h0);
        Reset = 1'b0;
        count_busy(nb, stray);
        chk("reclear_cycles", nb, 16);
        chk("busy_no_response", {31'h0, stray}, 32'h0);
        // RE stayed high, so the first edge with BUSY low accepts lw 0x10.
        @(negedge clk);
        RE = 1'b0;
        chk("post_clear_valid", {31'h0, RD_VALID}, 32'h1);
        chk("post_clear_rd_10", RD, 32'h0);
        RE = 1'b1; A = 32'h20;
        @(negedge clk);
        RE = 1'b0;
        chk("post_clear_rd_20", RD, 32'h0);
        @(negedge clk);
        chk("idle_rd_valid", {31'h0, RD_VALID}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
